// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the programmable serial-pattern detector.
package seq_detect_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } seq_state_t;

  // Width of the fill counter, which counts up to seq_len-1.
  function automatic int unsigned fill_w(input int unsigned seq_len);
    return $clog2(seq_len);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky saturation flag; clear beats increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count,
  output logic         o_sat
);

  logic [W-1:0] r_count;
  logic         r_sat;
  logic [W-1:0] w_count_inc;

  assign w_count_inc = r_count + 1'b1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (i_clr) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= w_count_inc;
      if (w_count_inc == {W{1'b1}}) begin
        r_sat <= 1'b1;
      end
    end
  end

  assign o_count = r_count;
  assign o_sat   = r_sat;

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable Mealy serial-pattern detector with overlap control and a
// saturating match counter.
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int unsigned SEQ_LEN = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [SEQ_LEN-1:0] i_pattern,
  input  logic               i_overlap_en,
  input  logic               i_pattern_load,
  input  logic               i_in_valid,
  input  logic               i_in_bit,
  input  logic               i_clear_count,
  output logic               o_match,
  output logic [CNT_W-1:0]   o_match_count,
  output logic               o_count_sat,
  output logic               o_armed
);

  localparam int unsigned FillW = fill_w(SEQ_LEN);
  localparam logic [FillW-1:0] FillMax = FillW'(SEQ_LEN - 1);

  seq_state_t r_state, w_state_d;

  logic [SEQ_LEN-1:0] r_pat;
  logic               r_ovl;
  logic [SEQ_LEN-2:0] r_hist;
  logic [FillW-1:0]   r_fill;

  logic [SEQ_LEN-1:0] w_window;
  logic               w_armed;
  logic               w_match;

  always_comb begin
    w_state_d = r_state;
    if (i_pattern_load) begin
      w_state_d = RUN;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_d;
    end
  end

  assign w_armed  = (r_state == RUN);
  // Window of the last SEQ_LEN valid bits, oldest at the MSB.
  assign w_window = {r_hist, i_in_bit};
  assign w_match  = w_armed & i_in_valid & ~i_pattern_load &
                    (r_fill == FillMax) & (w_window == r_pat);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pat  <= '0;
      r_ovl  <= 1'b0;
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_pattern_load) begin
      r_pat  <= i_pattern;
      r_ovl  <= i_overlap_en;
      r_hist <= '0;
      r_fill <= '0;
    end else if (w_armed && i_in_valid) begin
      r_hist <= w_window[SEQ_LEN-2:0];
      // Non-overlapping mode discards the matched window entirely.
      if (w_match && !r_ovl) begin
        r_fill <= '0;
      end else if (r_fill != FillMax) begin
        r_fill <= r_fill + 1'b1;
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_sat_counter (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_inc  (w_match),
    .i_clr  (i_clear_count),
    .o_count(o_match_count),
    .o_sat  (o_count_sat)
  );

  assign o_match = w_match;
  assign o_armed = w_armed;

endmodule

// File: doc/seq_detect_prog.md
# seq_detect_prog

Programmable Mealy serial-pattern detector: generalisation of the fixed 4-bit "1010" detector to a runtime-loadable pattern of `SEQ_LEN` bits, selectable overlapping/non-overlapping matching, input qualification, and a saturating match counter. It sits on a serial bit stream in the FSM exercise set. It also serves as the common detector for any later fixed-pattern variant.

## Interface
- `SEQ_LEN`, 4: pattern length in bits; legal range 2..32.
- `CNT_W`, 8: match-counter width; minimum 1.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pattern`  in  `SEQ_LEN`  pattern to detect; MSB is the first bit received. Sampled only on `pattern_load`.
- `overlap_en`  in  1  1 = overlapping, 0 = non-overlapping. Sampled only on `pattern_load`.
- `pattern_load`  in  1  capture `pattern`/`overlap_en`, flush history, enter RUN.
- `in_valid`  in  1  `in_bit` is valid this cycle.
- `in_bit`  in  1  serial data bit.
- `clear_count`  in  1  synchronous clear of `match_count` and `count_sat`.
- `match`  out  1  Mealy output: current valid bit completes the pattern.
- `match_count`  out  `CNT_W`  number of matches; saturating.
- `count_sat`  out  1  sticky flag: counter reached all-ones.
- `armed`  out  1  1 when in RUN.

## Operation
- **States:** IDLE (reset state; no pattern loaded) and RUN.
  - IDLE → RUN on `pattern_load`.
  - RUN → RUN on `pattern_load`, which reloads the pattern and mode.
  - Only `rst` returns the block to IDLE.
- **Registers:**
  - `pat_q` (`SEQ_LEN`) and `ovl_q` hold the captured pattern and mode.
  - `hist` (`SEQ_LEN-1` bits) holds the most recent valid bits; newest bit is the LSB.
  - `fill` counts valid bits held, saturating at `SEQ_LEN-1`.
- **Match rule:** `match = armed & in_valid & ~pattern_load & (fill == SEQ_LEN-1) & ({hist, in_bit} == pat_q)`.
- **Valid bit in RUN without load:**
  - Shift `in_bit` into `hist`.
  - `fill` increments, saturating.
  - If `match` and `ovl_q = 0`: `fill` ← 0, so history is discarded and no bit of the matched window is reused.
  - If `match` and `ovl_q = 1`: `fill` stays at `SEQ_LEN-1`.
- **`in_valid = 0`:** `hist` and `fill` hold. Gaps are invisible to matching.
- **`pattern_load`:**
  - Has priority over the data path.
  - That cycle's `in_bit` is ignored and `match` = 0.
  - `hist` ← 0, `fill` ← 0.
  - `match_count` is not affected.
- **Counter:**
  - On `match`, `match_count` increments.
  - At all-ones it holds and `count_sat` ← 1. `count_sat` is sticky until `clear_count` or `rst`.
  - `clear_count` wins over a same-cycle match: count ← 0, `count_sat` ← 0, and that match is not counted. The `match` output is still asserted.
- **Widths:** the pattern comparison is exactly `SEQ_LEN` bits. The counter is unsigned `CNT_W` bits with no wrap.

## Timing
- **Reset values:** `match` = 0, `match_count` = 0, `count_sat` = 0, `armed` = 0; `pat_q`, `ovl_q`, `hist`, `fill` = 0.
- **`match`:** combinational, asserted in the same cycle as the completing `in_bit`, with zero latency. It is valid only while `in_valid` is high.
- **`match_count`:** reflects a match after the next rising edge (latency 1).
- **`armed`:** rises on the edge that samples the first `pattern_load`.
- **First possible match:** the first pattern bit must arrive in the cycle after `pattern_load`. The earliest match is therefore `SEQ_LEN` valid bits after that cycle.
- **`rst` mid-stream:** asserting `rst` immediately forces IDLE and the reset values. `match` drops combinationally. A pattern must be reloaded afterwards.

## Structure
- **Package `seq_detect_pkg`:**
  - State enum `seq_state_t` {IDLE, RUN}.
  - Localparam function for the `fill` width, `$clog2(SEQ_LEN)`.
- **Sub-module `sat_counter`:** parameter `W`; inputs `clk`, `rst`, `inc`, `clr`; outputs `count`, `sat`. The clear-over-increment priority lives here.
- **Top level:** FSM, history shift register, fill counter, comparator and the `sat_counter` instance.

## Test plan
- **Overlapping:** `SEQ_LEN`=4, load `pattern`=4'b1010 with `overlap_en`=1, stream 1,0,1,0,1,0 all valid → `match` high on bits 4 and 6; `match_count` = 2.
- **Non-overlapping:** same load with `overlap_en`=0, stream 1,0,1,0,1,0,1,0 → `match` on bits 4 and 8 only; `match_count` = 2.
- **Valid gaps:** stream 1,0,1,0 with `in_valid` low for 3 cycles between bits 2 and 3 → single match on bit 4. Then reload `pattern`=4'b1111 while `in_bit`=1 → no match that cycle, and `hist` is flushed.
- **Saturation:** `CNT_W`=2, 5 overlapping matches → `match_count` holds 3 and `count_sat` = 1. Then `clear_count` asserted together with a match → count 0, `count_sat` 0, `match` still high that cycle.
- **Reset/IDLE:** `rst` pulsed mid-stream after 1,0,1 → outputs at reset values immediately, `armed` = 0. Streaming 1010 without a reload → no match.
- **Maximum length:** `SEQ_LEN`=32 with `pattern`=32'hDEADBEEF sent MSB first, preceded by 5 random bits → exactly one match, on the final bit.
